// File: rtl/vdcm_ssm_pkg.sv
// Shared widths and types for the VDC-M substream bit funnel.
package vdcm_ssm_pkg;

   localparam int unsigned SSM_IN_W        = 64;
   localparam int unsigned SSM_WIN_W       = 128;
   localparam int unsigned SSM_BUF_W       = 256;
   localparam int unsigned SSM_FILL_W      = 9;
   localparam int unsigned SSM_CNT_W       = 24;
   localparam int unsigned SSM_CONSUME_W   = 8;
   localparam int unsigned SSM_CONSUME_MAX = 128;

   typedef logic [SSM_FILL_W-1:0] fill_t;

endpackage

// File: rtl/ssm_shl.sv
// Logarithmic barrel shifter with zero-fill; direction fixed at elaboration.
module ssm_shl #(
   parameter int unsigned W     = 256,
   parameter int unsigned SH_W  = 8,
   parameter bit          RIGHT = 1'b0
) (
   input  logic [W-1:0]    din,
   input  logic [SH_W-1:0] sh,
   output logic [W-1:0]    dout
);

   logic [W-1:0] stage [SH_W+1];

   assign stage[0] = din;

   // One stage per shift-amount bit, each moving by a power of two.
   for (genvar i = 0; i < SH_W; i++) begin : g_stage
      if (RIGHT) begin : g_right
         assign stage[i+1] = sh[i] ? (stage[i] >> (2**i)) : stage[i];
      end else begin : g_left
         assign stage[i+1] = sh[i] ? (stage[i] << (2**i)) : stage[i];
      end
   end

   assign dout = stage[SH_W];

endmodule

// File: rtl/ssm_bit_funnel.sv
// Per-substream bit funnel: buffers 64-bit words and presents an MSB-aligned
// 128-bit window, dropping consumed bits and refilling behind them.
module ssm_bit_funnel
   import vdcm_ssm_pkg::*;
#(
   parameter int unsigned ssm_idx = 0,
   parameter int unsigned IN_W    = SSM_IN_W,
   parameter int unsigned WIN_W   = SSM_WIN_W,
   parameter int unsigned BUF_W   = SSM_BUF_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [IN_W-1:0]          in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIN_W-1:0]         suffix,
   output logic                     suffix_valid,
   input  logic                     consume_en,
   input  logic [SSM_CONSUME_W-1:0] consume_bits,
   output fill_t                    fill,
   output logic [SSM_CNT_W-1:0]     bit_count,
   output logic                     err
);

   localparam int unsigned FILL_W = SSM_FILL_W;
   localparam int unsigned EXT_W  = FILL_W + 1;
   localparam int unsigned SH_W   = $clog2(BUF_W);

   // Elaboration-time sanity checks on the parameter set.
   if (BUF_W < WIN_W + IN_W) begin : g_bad_buf
      $error("BUF_W must be at least WIN_W + IN_W");
   end
   if (ssm_idx > 255) begin : g_bad_idx
      $error("ssm_idx out of range");
   end

   logic [BUF_W-1:0]         data_q, data_d;
   fill_t                    fill_q, fill_d;
   logic [SSM_CNT_W-1:0]     cnt_q, cnt_d;
   logic                     err_q, err_d;

   logic                     legal;
   logic                     illegal;
   logic                     accept;
   logic [SSM_CONSUME_W-1:0] c;
   logic [EXT_W-1:0]         fill_rem;
   logic [BUF_W-1:0]         shifted;
   logic [BUF_W-1:0]         placed;

   assign suffix       = data_q[BUF_W-1 -: WIN_W];
   assign suffix_valid = (fill_q >= FILL_W'(WIN_W));
   assign in_ready     = (fill_q <= FILL_W'(BUF_W - IN_W)) && !flush;
   assign fill         = fill_q;
   assign bit_count    = cnt_q;
   assign err          = err_q;

   // Consume qualification; an illegal request shifts by zero.
   assign legal    = consume_en && suffix_valid &&
                     (consume_bits <= SSM_CONSUME_W'(SSM_CONSUME_MAX));
   assign illegal  = consume_en && !legal;
   assign c        = legal ? consume_bits : '0;
   assign accept   = in_valid && in_ready;
   assign fill_rem = EXT_W'(fill_q) - EXT_W'(c);

   ssm_shl #(
      .W     (BUF_W),
      .SH_W  (SH_W),
      .RIGHT (1'b0)
   ) u_consume_shl (
      .din  (data_q),
      .sh   (SH_W'(c)),
      .dout (shifted)
   );

   // New word lands immediately behind the bits that survive the consume.
   ssm_shl #(
      .W     (BUF_W),
      .SH_W  (SH_W),
      .RIGHT (1'b1)
   ) u_place_shr (
      .din  ({in_data, {(BUF_W-IN_W){1'b0}}}),
      .sh   (SH_W'(fill_rem)),
      .dout (placed)
   );

   always_comb begin
      data_d = data_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (flush) begin
         data_d = '0;
         fill_d = '0;
         cnt_d  = '0;
         err_d  = 1'b0;
      end else begin
         data_d = shifted | (accept ? placed : '0);
         fill_d = FILL_W'(fill_rem + (accept ? EXT_W'(IN_W) : '0));
         cnt_d  = cnt_q + SSM_CNT_W'(c);
         if (illegal) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_ssm_bit_funnel.sv
// Randomized and directed bench for ssm_bit_funnel against a bit-queue model.
module tb_ssm_bit_funnel;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [63:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] suffix;
   logic         suffix_valid;
   logic         consume_en;
   logic [7:0]   consume_bits;
   logic [8:0]   fill;
   logic [23:0]  bit_count;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: unconsumed bits in stream order, front is earliest.
   bit          q[$];
   logic [23:0] m_cnt;
   logic        m_err;

   always #5 clk = ~clk;

   ssm_bit_funnel dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .suffix       (suffix),
      .suffix_valid (suffix_valid),
      .consume_en   (consume_en),
      .consume_bits (consume_bits),
      .fill         (fill),
      .bit_count    (bit_count),
      .err          (err)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] m_suffix();
      logic [127:0] s;
      s = '0;
      for (int i = 0; i < 128; i++) begin
         if (i < q.size()) s[127-i] = q[i];
      end
      return s;
   endfunction

   task automatic m_clear();
      q.delete();
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   // Drive one cycle, check pre-edge outputs, advance model and clock.
   task automatic step(input logic iv, input logic [63:0] d, input logic cen,
                       input logic [7:0] cb, input logic fl);
      bit ok_consume;
      bit acc;
      in_valid     = iv;
      in_data      = d;
      consume_en   = cen;
      consume_bits = cb;
      flush        = fl;
      #1;
      check("suffix", suffix, m_suffix());
      check("suffix_valid", suffix_valid, q.size() >= 128);
      check("fill", fill, q.size());
      check("bit_count", bit_count, m_cnt);
      check("err", err, m_err);
      check("in_ready", in_ready, (q.size() <= 192) && !fl);
      ok_consume = cen && (q.size() >= 128) && (cb <= 128);
      acc        = iv && (q.size() <= 192) && !fl;
      if (fl) begin
         m_clear();
      end else begin
         if (ok_consume) begin
            for (int i = 0; i < int'(cb); i++) void'(q.pop_front());
            m_cnt = m_cnt + 24'(cb);
         end
         if (cen && !ok_consume) m_err = 1'b1;
         if (acc) begin
            for (int i = 63; i >= 0; i--) q.push_back(d[i]);
         end
      end
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      consume_en = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic push(input logic [63:0] d);
      step(1'b1, d, 1'b0, 8'd0, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, 64'd0, 1'b0, 8'd0, 1'b1);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_rst();
      #2;
      rst = 1'b1;
      #1;
      check("rst_fill", fill, 0);
      check("rst_suffix", suffix, 0);
      check("rst_suffix_valid", suffix_valid, 0);
      check("rst_bit_count", bit_count, 0);
      check("rst_err", err, 0);
      m_clear();
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] A = 64'h0123456789ABCDEF;
   localparam logic [63:0] B = 64'hFEDCBA9876543210;
   localparam logic [63:0] C = 64'hAAAAAAAAAAAAAAAA;

   initial begin
      logic [191:0] abc;
      logic [63:0]  w [4];
      logic [7:0]   cb;

      rst          = 1'b1;
      flush        = 1'b0;
      in_data      = '0;
      in_valid     = 1'b0;
      consume_en   = 1'b0;
      consume_bits = '0;
      m_clear();
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset and prime
      check("reset_in_ready", in_ready, 1);
      push(A);
      push(B);
      check("prime_suffix", suffix, {A, B});
      check("prime_valid", suffix_valid, 1);
      check("prime_fill", fill, 128);

      // Consume 28 with simultaneous refill
      step(1'b1, C, 1'b1, 8'd28, 1'b0);
      abc = {A, B, C};
      abc = abc << 28;
      check("refill_suffix", suffix, abc[191:64]);
      check("refill_fill", fill, 164);
      check("refill_bit_count", bit_count, 28);

      // Back-pressure
      do_flush();
      for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) push(w[i]);
      check("bp_fill192", fill, 192);
      check("bp_ready192", in_ready, 1);
      push(w[3]);
      check("bp_fill256", fill, 256);
      check("bp_ready256", in_ready, 0);
      push(64'hDEADBEEFDEADBEEF);
      check("bp_held_fill", fill, 256);

      // Max consume with simultaneous accept at fill 192
      do_flush();
      for (int i = 0; i < 3; i++) push(w[i]);
      step(1'b1, w[3], 1'b1, 8'd128, 1'b0);
      check("max_fill", fill, 128);
      check("max_suffix", suffix, {w[2], w[3]});
      check("max_bit_count", bit_count, 128);

      // Illegal consume without a valid window
      do_flush();
      push(A);
      step(1'b0, 64'd0, 1'b1, 8'd8, 1'b0);
      check("ill_small_err", err, 1);
      check("ill_small_fill", fill, 64);
      check("ill_small_cnt", bit_count, 0);

      // Illegal consume above 128
      do_flush();
      check("flush_err_clear", err, 0);
      for (int i = 0; i < 4; i++) push(w[i]);
      step(1'b0, 64'd0, 1'b1, 8'd56, 1'b0);
      check("ill_big_pre_fill", fill, 200);
      step(1'b0, 64'd0, 1'b1, 8'd200, 1'b0);
      check("ill_big_err", err, 1);
      check("ill_big_fill", fill, 200);
      check("ill_big_cnt", bit_count, 56);
      step(1'b0, 64'd0, 1'b1, 8'd0, 1'b0);

      // Flush while a word is offered
      do_flush();
      for (int i = 0; i < 3; i++) push(w[i]);
      step(1'b1, C, 1'b0, 8'd0, 1'b1);
      check("flush_fill", fill, 0);
      check("flush_err", err, 0);
      check("flush_cnt", bit_count, 0);

      // Reset mid-stream
      push(A);
      push(B);
      step(1'b1, C, 1'b1, 8'd17, 1'b0);
      pulse_rst();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) cb = 8'($urandom_range(129, 255));
         else                            cb = 8'($urandom_range(0, 128));
         step($urandom_range(0, 9) < 7, {$urandom, $urandom},
              $urandom_range(0, 9) < 6, cb, $urandom_range(0, 99) == 0);
         if (n % 700 == 699) pulse_rst();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
